// File: rtl/pix_reset_seq.sv
// pix_reset_seq
//
// Pixel-domain reset sequencer. Synchronises the clock generator's
// asynchronous lock flag into clk_25m, holds the pixel domain in reset until
// lock has been stable for HOLD_CYCLES cycles, and re-asserts reset as soon
// as lock is lost.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth for locked (>= 2)
//   HOLD_CYCLES  cycles locked must stay high before reset releases (>= 1)
//
// Ports:
//   clk_25m     in   pixel clock, sole clock
//   reset       in   asynchronous active-high reset
//   locked      in   clock-generator lock status, asynchronous to clk_25m
//   rst_pix     out  registered active-high reset for pixel-domain logic
//   ready       out  registered, always the complement of rst_pix
//   loss_count  out  saturating count of lock-loss events while running
//
// Build option:
//   PIX_RESET_SEQ_LOSS_CNT_EN  when defined, loss_count counts RUN -> WAIT_LOCK
//                              transitions (saturating at 255); otherwise it
//                              is tied to zero and no counter flops exist.
module pix_reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk_25m,
  input  logic       reset,
  input  logic       locked,
  output logic       rst_pix,
  output logic       ready,
  output logic [7:0] loss_count
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [SYNC_STAGES-1:0] locked_sync;
  logic                   locked_s;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nx;

  assign locked_s = locked_sync[SYNC_STAGES-1];

  // Next-state decode. In SETTLE a drop of lock is tested before the
  // terminal count so that a loss on the final settle cycle keeps reset high.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nx = SETTLE;
          cnt_nx   = '0;
        end
      end
      SETTLE: begin
        if (!locked_s) begin
          state_nx = WAIT_LOCK;
        end else if (cnt == CNT_LAST) begin
          state_nx = RUN;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nx = WAIT_LOCK;
        end
      end
      default: state_nx = WAIT_LOCK;
    endcase
  end

  // Synchroniser, state register and registered outputs. rst_pix and ready
  // are both derived from state_nx so they switch on the same edge the state
  // enters or leaves RUN and can never disagree.
  always_ff @(posedge clk_25m or posedge reset) begin
    if (reset) begin
      locked_sync <= '0;
      state       <= WAIT_LOCK;
      cnt         <= '0;
      rst_pix     <= 1'b1;
      ready       <= 1'b0;
    end else begin
      locked_sync <= {locked_sync[SYNC_STAGES-2:0], locked};
      state       <= state_nx;
      cnt         <= cnt_nx;
      rst_pix     <= (state_nx != RUN);
      ready       <= (state_nx == RUN);
    end
  end

`ifdef PIX_RESET_SEQ_LOSS_CNT_EN
  logic loss_evt;

  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  assign loss_evt = (state == RUN) && (state_nx == WAIT_LOCK);

  always_ff @(posedge clk_25m or posedge reset) begin
    if (reset) begin
      loss_count <= 8'd0;
    end else if (loss_evt) begin
      loss_count <= sat_inc(loss_count);
    end
  end
`else
  assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pix_reset_seq.sv
// Directed testbench for pix_reset_seq with default parameters
// (SYNC_STAGES=2, HOLD_CYCLES=16). Inputs change on the falling edge; outputs
// are sampled 1 ns after the rising edge, so "after Ek" is directly observable.
module tb_pix_reset_seq;

`ifdef PIX_RESET_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clk_25m;
  logic       reset;
  logic       locked;
  logic       rst_pix;
  logic       ready;
  logic [7:0] loss_count;

  int n_checks;
  int n_pass;
  int exp_loss;

  pix_reset_seq #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(16)
  ) dut (
    .clk_25m   (clk_25m),
    .reset     (reset),
    .locked    (locked),
    .rst_pix   (rst_pix),
    .ready     (ready),
    .loss_count(loss_count)
  );

  initial clk_25m = 1'b0;
  always #20 clk_25m = ~clk_25m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Advance n rising edges and sample 1 ns after the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk_25m);
    #1;
  endtask

  task automatic set_locked(input logic v);
    @(negedge clk_25m);
    locked = v;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_loss = 0;
    reset    = 1'b1;
    locked   = 1'b0;

    // Power-up: reset values are visible before any clock edge.
    #5;
    chk("por_rst_pix", rst_pix, 1);
    chk("por_ready", ready, 0);
    chk("por_loss", loss_count, 0);
    edges(3);
    @(negedge clk_25m);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      edges(1);
      chk($sformatf("nolock_rst_pix_%0d", i), rst_pix, 1);
    end
    chk("nolock_ready", ready, 0);
    chk("nolock_loss", loss_count, 0);

    // Clean lock: next rising edge is E0; release after E18.
    set_locked(1'b1);
    edges(10);                      // after E9, in SETTLE
    chk("lock_e9_rst_pix", rst_pix, 1);
    edges(8);                       // after E17
    chk("lock_e17_rst_pix", rst_pix, 1);
    chk("lock_e17_ready", ready, 0);
    edges(1);                       // after E18
    chk("lock_e18_rst_pix", rst_pix, 0);
    chk("lock_e18_ready", ready, 1);
    edges(5);
    chk("run_hold_ready", ready, 1);

    // Lock loss from RUN: rst_pix rises after E2.
    set_locked(1'b0);
    edges(2);                       // after E1
    chk("loss_e1_rst_pix", rst_pix, 0);
    edges(1);                       // after E2
    chk("loss_e2_rst_pix", rst_pix, 1);
    chk("loss_e2_ready", ready, 0);
    exp_loss = LOSS_EN ? 1 : 0;
    chk("loss_count_1", loss_count, exp_loss);

    // Relock: release 18 edges after the re-rise is first sampled.
    edges(3);
    set_locked(1'b1);
    edges(18);                      // after E17
    chk("relock_e17_rst_pix", rst_pix, 1);
    edges(1);                       // after E18
    chk("relock_e18_rst_pix", rst_pix, 0);
    chk("relock_e18_ready", ready, 1);

    // Settle glitch: lose lock, then 10 high / 3 low / high.
    set_locked(1'b0);
    edges(6);
    chk("glitch_pre_rst_pix", rst_pix, 1);
    exp_loss = LOSS_EN ? 2 : 0;
    chk("loss_count_2", loss_count, exp_loss);
    set_locked(1'b1);
    for (int i = 0; i < 10; i++) begin
      edges(1);
      chk($sformatf("glitch_hi_rst_pix_%0d", i), rst_pix, 1);
    end
    @(negedge clk_25m);
    locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      chk($sformatf("glitch_lo_rst_pix_%0d", i), rst_pix, 1);
    end
    @(negedge clk_25m);
    locked = 1'b1;                  // next rising edge is R0
    edges(18);                      // after R17
    chk("glitch_r17_rst_pix", rst_pix, 1);
    edges(1);                       // after R18
    chk("glitch_r18_rst_pix", rst_pix, 0);
    chk("glitch_r18_ready", ready, 1);
    chk("glitch_no_loss_inc", loss_count, exp_loss);

    // Saturation: loss_count is 2 here (macro on). 253 cycles -> 255 exactly,
    // then more cycles must not wrap.
    for (int i = 0; i < 252; i++) begin
      set_locked(1'b0);
      edges(4);
      set_locked(1'b1);
      edges(20);
    end
    exp_loss = LOSS_EN ? 254 : 0;
    chk("sat_loss_254", loss_count, exp_loss);
    chk("sat_iter_ready", ready, 1);
    for (int i = 0; i < 48; i++) begin
      set_locked(1'b0);
      edges(4);
      set_locked(1'b1);
      edges(20);
    end
    exp_loss = LOSS_EN ? 255 : 0;
    chk("sat_loss_255", loss_count, exp_loss);
    set_locked(1'b0);
    edges(4);
    chk("sat_loss_nowrap", loss_count, exp_loss);

    // Async reset mid-SETTLE at cnt=8 with locked held high.
    set_locked(1'b1);
    edges(11);                      // after E10: cnt=8
    chk("settle_rst_pix", rst_pix, 1);
    #5;
    reset = 1'b1;
    #1;
    chk("arst_settle_rst_pix", rst_pix, 1);
    chk("arst_settle_ready", ready, 0);
    chk("arst_settle_loss", loss_count, 0);
    #5;
    reset = 1'b0;                   // next rising edge is E0
    edges(18);                      // after E17
    chk("arst_seq_e17_rst_pix", rst_pix, 1);
    edges(1);                       // after E18
    chk("arst_seq_e18_rst_pix", rst_pix, 0);
    chk("arst_seq_e18_ready", ready, 1);

    // Async reset mid-RUN: ready drops without a clock edge.
    #5;
    reset = 1'b1;
    #1;
    chk("arst_run_rst_pix", rst_pix, 1);
    chk("arst_run_ready", ready, 0);
    chk("arst_run_loss", loss_count, 0);
    #5;
    reset = 1'b0;
    edges(18);
    chk("arst_run_e17_rst_pix", rst_pix, 1);
    edges(1);
    chk("arst_run_e18_ready", ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
